// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch unit.
package instr_fetch_pkg;

    typedef enum logic [2:0] {
        ST_BOOT    = 3'd0,
        ST_HANDOFF = 3'd1,
        ST_RUN     = 3'd2,
        ST_HALTED  = 3'd3,
        ST_FAULT   = 3'd4
    } fetch_state_t;

    // Opcode field (bits 31:26) that decode recognises as halt.
    localparam logic [5:0] HALT_OPCODE = 6'b011000;

    // Number of valid words in the boot ROM.
    localparam int BIOS_SIZE_DEFAULT = 81;

endpackage

// File: rtl/instr_fetch_pc_reg.sv
// Program counter register with its next-PC mux and incrementer.
module pc_reg #(
    parameter int PC_W = 26
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            inc,
    input  logic            load,
    input  logic [PC_W-1:0] load_addr,
    output logic [PC_W-1:0] pc
);

    logic [PC_W-1:0] pc_next;

    // Next-PC select: a load beats an increment; otherwise hold.
    always_comb begin
        pc_next = pc;
        if (load) begin
            pc_next = load_addr;
        end else if (inc) begin
            pc_next = pc + PC_W'(1);
        end
    end

    // PC register, cleared to the first boot ROM word on reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc <= '0;
        end else begin
            pc <= pc_next;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: boot/run FSM, instruction register, and PC control.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int BIOS_SIZE  = BIOS_SIZE_DEFAULT,
    parameter int PC_W       = 26,
    parameter int USER_START = 0
) (
    input  logic            clock,
    input  logic            reset,
    output logic [PC_W-1:0] pc,
    input  logic [31:0]     bios_instr,
    input  logic [31:0]     mem_instr,
    input  logic            stall,
    input  logic            jump_en,
    input  logic [PC_W-1:0] jump_addr,
    input  logic            halt,
    input  logic            resume,
    output logic [31:0]     instrucao,
    output logic [PC_W-1:0] instr_pc,
    output logic            instr_valid,
    output logic            boot_mode,
    output logic            fault
);

    localparam logic [PC_W-1:0] BIOS_LIMIT = PC_W'(BIOS_SIZE);
    localparam logic [PC_W-1:0] USER_PC    = PC_W'(USER_START);

    fetch_state_t    state, state_next;
    logic            pc_inc, pc_load;
    logic [PC_W-1:0] pc_load_addr;
    logic            capture, flush;
    logic [31:0]     fetch_word;

    assign fetch_word = (state == ST_BOOT) ? bios_instr : mem_instr;
    assign boot_mode  = (state == ST_BOOT);
    assign fault      = (state == ST_FAULT);

    pc_reg #(
        .PC_W(PC_W)
    ) u_pc_reg (
        .clock    (clock),
        .reset    (reset),
        .inc      (pc_inc),
        .load     (pc_load),
        .load_addr(pc_load_addr),
        .pc       (pc)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_BOOT;
        end else begin
            state <= state_next;
        end
    end

    // Next state and per-edge actions; priority halt > jump > stall > sequential.
    always_comb begin
        state_next   = state;
        pc_inc       = 1'b0;
        pc_load      = 1'b0;
        pc_load_addr = jump_addr;
        capture      = 1'b0;
        flush        = 1'b0;
        case (state)
            ST_BOOT: begin
                if (halt) begin
                    state_next   = ST_HANDOFF;
                    pc_load      = 1'b1;
                    pc_load_addr = USER_PC;
                    flush        = 1'b1;
                end else if (jump_en) begin
                    pc_load = 1'b1;
                    flush   = 1'b1;
                end else if (stall) begin
                    // hold everything
                end else if (pc >= BIOS_LIMIT) begin
                    // Boot PC ran off the ROM: refuse to capture garbage.
                    state_next = ST_FAULT;
                    flush      = 1'b1;
                end else begin
                    capture = 1'b1;
                    pc_inc  = 1'b1;
                end
            end
            ST_HANDOFF: begin
                // One dead cycle while the source switches to user memory.
                state_next = ST_RUN;
            end
            ST_RUN: begin
                if (halt) begin
                    state_next = ST_HALTED;
                    flush      = 1'b1;
                end else if (jump_en) begin
                    pc_load = 1'b1;
                    flush   = 1'b1;
                end else if (stall) begin
                    // hold everything
                end else begin
                    capture = 1'b1;
                    pc_inc  = 1'b1;
                end
            end
            ST_HALTED: begin
                // Only resume matters here; the frozen pc is where fetch restarts.
                if (resume) begin
                    state_next = ST_RUN;
                end
            end
            ST_FAULT: begin
                // Sticky until reset.
            end
            default: begin
                state_next = ST_FAULT;
            end
        endcase
    end

    // Instruction register: capture the selected word, or drop valid on a flush.
    always_ff @(posedge clock) begin
        if (reset) begin
            instrucao   <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
        end else if (capture) begin
            instrucao   <= fetch_word;
            instr_pc    <= pc;
            instr_valid <= 1'b1;
        end else if (flush) begin
            instr_valid <= 1'b0;
        end
    end

endmodule
